// File: rtl/des_decrypt_iter.sv
`default_nettype none
// ============================================================================
// Module      : des_decrypt_iter
// Description : Iterative DES decryption engine. One block in flight at a
//               time; ROUNDS_PER_CYCLE Feistel rounds are evaluated per clock
//               using the reversed (right-rotating) key schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module des_decrypt_iter #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [63:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);
    localparam int c_rpc = ROUNDS_PER_CYCLE;

    if (!(c_rpc == 1 || c_rpc == 2 || c_rpc == 4 || c_rpc == 8 || c_rpc == 16)) begin : g_bad_rpc
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    // Permutation tables, DES 1-based bit numbers (bit 1 = MSB)
    localparam int c_ip [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int c_fp [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int c_pc1 [56] = '{57,49,41,33,25,17,9,1, 58,50,42,34,26,18,10,2,
                                  59,51,43,35,27,19,11,3, 60,52,44,36,63,55,47,39,
                                  31,23,15,7,62,54,46,38, 30,22,14,6,61,53,45,37,
                                  29,21,13,5,28,20,12,4};
    localparam int c_pc2 [48] = '{14,17,11,24,1,5,3,28, 15,6,21,10,23,19,12,4,
                                  26,8,16,7,27,20,13,2, 41,52,31,37,47,55,30,40,
                                  51,45,33,48,44,49,39,56, 34,53,46,42,50,36,29,32};
    localparam int c_e [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int c_p [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    // S-boxes: 64 nibbles each, entry (row*16+col) at nibble position from the MSB
    localparam logic [255:0] c_sbox [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_l, r_r, w_l_fin, w_r_fin;
    logic [27:0] r_c, r_d;
    logic [4:0]  r_rnd;
    logic [63:0] r_out_data, w_ip, w_pre, w_fp;
    logic        r_out_valid, w_last, w_unused_parity;
    logic [55:0] w_pc1;

    // Parity bits of the key never reach PC1
    assign w_unused_parity = ^{in_key[56], in_key[48], in_key[40], in_key[32],
                               in_key[24], in_key[16], in_key[8], in_key[0]};

    for (genvar i = 0; i < 64; i++) begin : g_ip
        assign w_ip[63-i] = in_data[64 - c_ip[i]];
        assign w_fp[63-i] = w_pre[64 - c_fp[i]];
    end
    for (genvar i = 0; i < 56; i++) begin : g_pc1
        assign w_pc1[55-i] = in_key[64 - c_pc1[i]];
    end

    // Unrolled group of rounds; each stage feeds the next, the last feeds the registers
    for (genvar g = 0; g < c_rpc; g++) begin : g_round
        logic [31:0] w_li, w_ri, w_lo, w_ro, w_s, w_f;
        logic [27:0] w_ci, w_di, w_co, w_do;
        logic [47:0] w_k, w_ex, w_x;
        logic [4:0]  w_j;
        logic [1:0]  w_sh;

        if (g == 0) begin : g_first
            assign w_li = r_l;
            assign w_ri = r_r;
            assign w_ci = r_c;
            assign w_di = r_d;
        end else begin : g_next
            assign w_li = g_round[g-1].w_lo;
            assign w_ri = g_round[g-1].w_ro;
            assign w_ci = g_round[g-1].w_co;
            assign w_di = g_round[g-1].w_do;
        end

        // Zero-based round index; round 1 uses the PC1 key unrotated (K16)
        assign w_j  = r_rnd + 5'(g);
        assign w_sh = (w_j == 5'd0) ? 2'd0 :
                      (w_j == 5'd1 || w_j == 5'd8 || w_j == 5'd15) ? 2'd1 : 2'd2;
        assign w_co = (w_sh == 2'd0) ? w_ci : (w_sh == 2'd1) ? {w_ci[0], w_ci[27:1]}
                                                             : {w_ci[1:0], w_ci[27:2]};
        assign w_do = (w_sh == 2'd0) ? w_di : (w_sh == 2'd1) ? {w_di[0], w_di[27:1]}
                                                             : {w_di[1:0], w_di[27:2]};

        for (genvar i = 0; i < 48; i++) begin : g_pc2
            if (c_pc2[i] <= 28) begin : g_c
                assign w_k[47-i] = w_co[28 - c_pc2[i]];
            end else begin : g_d
                assign w_k[47-i] = w_do[56 - c_pc2[i]];
            end
            assign w_ex[47-i] = w_ri[32 - c_e[i]];
        end
        assign w_x = w_ex ^ w_k;

        for (genvar s = 0; s < 8; s++) begin : g_sbox
            logic [5:0] w_six;
            assign w_six = w_x[47-6*s -: 6];
            assign w_s[31-4*s -: 4] =
                c_sbox[s][8'd255 - {w_six[5], w_six[0], w_six[4:1], 2'b00} -: 4];
        end
        for (genvar i = 0; i < 32; i++) begin : g_p
            assign w_f[31-i] = w_s[32 - c_p[i]];
        end

        assign w_lo = w_ri;
        assign w_ro = w_li ^ w_f;
    end

    assign w_l_fin = g_round[c_rpc-1].w_lo;
    assign w_r_fin = g_round[c_rpc-1].w_ro;
    // No swap after round 16: preoutput is {R16, L16}
    assign w_pre   = {w_r_fin, w_l_fin};
    assign w_last  = ({1'b0, r_rnd} + 6'(c_rpc)) >= 6'd16;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_state_nxt = S_RUN;
            end
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Block registers: load on accept, advance during RUN, publish on the last round
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_l         <= '0;
            r_r         <= '0;
            r_c         <= '0;
            r_d         <= '0;
            r_rnd       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    {r_l, r_r} <= w_ip;
                    r_c        <= w_pc1[55:28];
                    r_d        <= w_pc1[27:0];
                    r_rnd      <= '0;
                end
                S_RUN: begin
                    r_l   <= w_l_fin;
                    r_r   <= w_r_fin;
                    r_c   <= g_round[c_rpc-1].w_co;
                    r_d   <= g_round[c_rpc-1].w_do;
                    r_rnd <= r_rnd + 5'(c_rpc);
                    if (w_last) begin
                        r_out_data  <= w_fp;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE:  if (out_ready) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_des_decrypt_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_des_decrypt_iter
// Description : Self-checking bench for des_decrypt_iter: known vectors,
//               backpressure, reset abort, ignored input, and random
//               encrypt/decrypt round trips against a textbook DES model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_des_decrypt_iter;
    parameter int RPC = 1;
    localparam int c_lat = 16 / RPC;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic [63:0] in_data, in_key, out_data;
    int          n_checks = 0;
    int          n_fail   = 0;

    des_decrypt_iter #(.ROUNDS_PER_CYCLE(RPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- textbook DES reference model ----------------
    int ip_t[$]  = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,
                     64,56,48,40,32,24,16,8,57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                     61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
    int fp_t[$]  = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,
                     37,5,45,13,53,21,61,29,36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                     34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
    int pc1_t[$] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                     60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                     29,21,13,5,28,20,12,4};
    int pc2_t[$] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int e_t[$]   = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                     16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    int p_t[$]   = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,
                     19,13,30,6,22,11,4,25};
    int sh_t[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    logic [63:0] sb [8][4] = '{
        '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}};

    // Generic permutation: result right-aligned, table entry 1 = MSB of an inw-bit input
    function automatic logic [63:0] perm(input logic [63:0] x, input int inw, input int t[$]);
        logic [63:0] y = '0;
        foreach (t[i]) y = (y << 1) | ((x >> (inw - t[i])) & 64'd1);
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s = '0;
        int six, row, col;
        e = 48'(perm({32'd0, r}, 32, e_t)) ^ k;
        for (int i = 0; i < 8; i++) begin
            six = int'((e >> (42 - 6 * i)) & 48'h3F);
            row = ((six >> 4) & 2) | (six & 1);
            col = (six >> 1) & 15;
            s   = (s << 4) | 32'((sb[i][row] >> (60 - 4 * col)) & 64'hF);
        end
        return 32'(perm({32'd0, s}, 32, p_t));
    endfunction

    function automatic logic [63:0] des(input logic [63:0] blk, input logic [63:0] key, input bit dec);
        logic [47:0] ks [16];
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [63:0] t;
        logic [31:0] l, r, tmp;
        cd = 56'(perm(key, 64, pc1_t));
        c  = cd[55:28];
        d  = cd[27:0];
        for (int k = 0; k < 16; k++) begin
            for (int n = 0; n < sh_t[k]; n++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            ks[k] = 48'(perm({8'd0, c, d}, 56, pc2_t));
        end
        t = perm(blk, 64, ip_t);
        l = t[63:32];
        r = t[31:0];
        for (int k = 0; k < 16; k++) begin
            tmp = r;
            r   = l ^ feistel(r, ks[dec ? 15 - k : k]);
            l   = tmp;
        end
        return perm({r, l}, 64, fp_t);
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] ct, input logic [63:0] key);
        int w = 0;
        while (!in_ready && w < 50) begin tick(); w++; end
        in_valid = 1'b1;
        in_data  = ct;
        in_key   = key;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 64) begin tick(); lat++; end
    endtask

    task automatic run_vec(input string name, input logic [63:0] ct, input logic [63:0] key,
                           input logic [63:0] pt);
        int lat;
        send(ct, key);
        check({name, " busy/in_ready"}, {62'd0, busy, in_ready}, 64'h2);
        wait_out(lat);
        check({name, " latency"}, 64'(lat), 64'(c_lat));
        check({name, " data"}, out_data, pt);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, " release"}, {62'd0, out_valid, in_ready}, 64'h1);
    endtask

    typedef struct {
        logic [63:0] ct;
        logic [63:0] key;
        logic [63:0] pt;
    } vec_t;

    initial begin
        vec_t        vecs[4];
        int          lat, bad, cnt;
        logic [63:0] key, pt, ct;

        vecs[0] = '{64'h85E813540F0AB405, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF};
        vecs[1] = '{64'h0000000000000000, 64'h0E329232EA6D0D73, 64'h8787878787878787};
        vecs[2] = '{64'h0000000000000000, 64'h0E329232EA6D0D73 ^ 64'h0101010101010101,
                    64'h8787878787878787};
        vecs[3] = '{64'h85E813540F0AB405, 64'h133457799BBCDFF1 ^ 64'h0101010101010101,
                    64'h0123456789ABCDEF};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_key = '0;
        tick(); tick();
        check("reset flags", {61'd0, out_valid, busy, in_ready}, 64'h1);
        check("reset data", out_data, 64'd0);
        rst_n = 1'b1;
        tick();
        check("post-reset flags", {61'd0, out_valid, busy, in_ready}, 64'h1);

        // Known vectors, including parity-flipped keys
        for (int i = 0; i < 4; i++) run_vec($sformatf("vec%0d", i), vecs[i].ct, vecs[i].key, vecs[i].pt);

        // Backpressure: result held for 10 cycles, then IDLE one cycle after out_ready
        send(vecs[0].ct, vecs[0].key);
        wait_out(lat);
        check("bp latency", 64'(lat), 64'(c_lat));
        for (int i = 0; i < 10; i++) begin
            check("bp hold flags", {61'd0, out_valid, busy, in_ready}, 64'h6);
            check("bp hold data", out_data, vecs[0].pt);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp release", {61'd0, out_valid, busy, in_ready}, 64'h1);

        // Reset in the middle of a block
        send(vecs[0].ct, vecs[0].key);
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        check("mid reset flags", {61'd0, out_valid, busy, in_ready}, 64'h1);
        check("mid reset data", out_data, 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid || busy) cnt++;
            tick();
        end
        check("no spurious output", 64'(cnt), 64'd0);
        run_vec("after reset", vecs[1].ct, vecs[1].key, vecs[1].pt);

        // in_valid held with changing data while the engine is busy
        in_valid = 1'b1; in_data = vecs[0].ct; in_key = vecs[0].key;
        tick();
        bad = 0; lat = 0;
        while (!out_valid && lat < 64) begin
            in_data = {$urandom, $urandom};
            in_key  = {$urandom, $urandom};
            if (in_ready) bad++;
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check("ignore in_ready", 64'(bad), 64'd0);
        check("ignore latency", 64'(lat), 64'(c_lat));
        check("ignore data", out_data, vecs[0].pt);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Random round trips: model encrypts, DUT must recover the plaintext
        for (int n = 0; n < 1000 && n_fail < 50; n++) begin
            key = {$urandom, $urandom};
            pt  = {$urandom, $urandom};
            ct  = des(pt, key, 1'b0);
            send(ct, key);
            wait_out(lat);
            check("rand latency", 64'(lat), 64'(c_lat));
            repeat ($urandom_range(0, 3)) tick();
            check("rand data", out_data, pt);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
